// File: rtl/sb_credit_loop_ctrl.sv
// sb_credit_loop_ctrl
//   Sideband RDI credit-loop controller. Tracks the credits the PHY may use
//   to send config messages to the adapter, and returns adapter-to-PHY
//   credits through a pending queue with optional coalescing and timeout.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_tx_fifo_read_en          TX FIFO pop (one pulse per message)
//   i_srcid                    srcid of the popped message
//   i_fifo_data_is_zeros       popped word is empty
//   i_lp_cfg_crd               adapter returns one credit per high cycle
//   i_pl_inband_pres           link present (low = link down, flush)
//   i_rising_edge_pl_cfg_vld   PHY sent one message to the adapter
//   o_pl_cfg_crd               credit return to the adapter, one per high cycle
//   o_adapter_is_full          PHY must not send to the adapter
//   o_tx_credits               credits currently available to the PHY
//   o_crd_pend                 credits owed to the adapter, not yet returned
//   o_crd_err                  sticky over/underflow flag
//
// Handshake: these are pulse interfaces, not valid/ready. Every cycle an
// input pulse is high counts as exactly one message/credit; nothing is ever
// back-pressured, so overflow is flagged on o_crd_err instead of stalled.
module sb_credit_loop_ctrl #(
  parameter int         ADP_CRD      = 32,
  parameter int         PHY_CRD      = 32,
  parameter logic [1:0] ADP_SRCID    = 2'b01,
  parameter int         COAL_THR     = 1,
  parameter int         COAL_TIMEOUT = 0,
  localparam int        CW           = $clog2(ADP_CRD + 1),
  localparam int        PW           = $clog2(PHY_CRD + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_tx_fifo_read_en,
  input  logic [1:0]    i_srcid,
  input  logic          i_fifo_data_is_zeros,
  input  logic          i_lp_cfg_crd,
  input  logic          i_pl_inband_pres,
  input  logic          i_rising_edge_pl_cfg_vld,
  output logic          o_pl_cfg_crd,
  output logic          o_adapter_is_full,
  output logic [CW-1:0] o_tx_credits,
  output logic [PW-1:0] o_crd_pend,
  output logic          o_crd_err
);

  localparam int            TW      = (COAL_TIMEOUT > 1) ? $clog2(COAL_TIMEOUT + 1) : 1;
  localparam int            TO_LAST = (COAL_TIMEOUT > 0) ? COAL_TIMEOUT - 1 : 0;
  localparam logic          TO_EN   = (COAL_TIMEOUT != 0);
  localparam logic [CW-1:0] ADP_MAX = CW'(ADP_CRD);
  localparam logic [PW-1:0] PHY_MAX = PW'(PHY_CRD);
  localparam logic [PW-1:0] THR_P   = PW'(COAL_THR);
  localparam logic [TW-1:0] TO_LAST_V = TW'(TO_LAST);

  typedef enum logic [0:0] {ST_IDLE, ST_RETURN} state_t;

  state_t        state;
  logic          pres_q;
  logic          pres_qq;
  logic [TW-1:0] timer;

  logic          link_up;
  logic          cons;
  logic          ret;
  logic          tx_under;
  logic          tx_over;
  logic          rd_event;
  logic          fire;
  logic          issue;
  logic          pend_sat;
  logic [PW-1:0] pend_next;

  // Link up is taken from the registered copy so the credit load lands one
  // edge after the edge that first samples the link present.
  assign link_up  = pres_q & ~pres_qq;

  assign cons     = i_rising_edge_pl_cfg_vld;
  assign ret      = i_lp_cfg_crd;
  assign tx_under = cons & ~ret & (o_tx_credits == '0);
  assign tx_over  = ret & ~cons & (o_tx_credits == ADP_MAX);

  assign rd_event = i_tx_fifo_read_en & (i_srcid == ADP_SRCID) &
                    ~i_fifo_data_is_zeros & i_pl_inband_pres;

  // Burst start from IDLE: threshold reached, or the idle timer expired.
  // The timer compares against TIMEOUT-1 so the first return lands exactly
  // TIMEOUT cycles after the queue first became nonzero.
  assign fire  = (state == ST_IDLE) &
                 ((o_crd_pend >= THR_P) |
                  (TO_EN & (o_crd_pend != '0) & (timer == TO_LAST_V)));
  assign issue = fire | ((state == ST_RETURN) & (o_crd_pend != '0));

  assign pend_sat = rd_event & ~issue & (o_crd_pend == PHY_MAX);

  always_comb begin
    pend_next = o_crd_pend;
    if (rd_event & ~issue & (o_crd_pend != PHY_MAX))
      pend_next = o_crd_pend + 1'b1;
    else if (issue & ~rd_event)
      pend_next = o_crd_pend - 1'b1;
  end

  assign o_adapter_is_full = (o_tx_credits == '0) | ~i_pl_inband_pres;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      pres_q       <= 1'b0;
      pres_qq      <= 1'b0;
      timer        <= '0;
      o_pl_cfg_crd <= 1'b0;
      o_tx_credits <= '0;
      o_crd_pend   <= '0;
      o_crd_err    <= 1'b0;
    end else begin
      pres_q  <= i_pl_inband_pres;
      pres_qq <= pres_q;
      if (!i_pl_inband_pres) begin
        // Link down: flush everything except the sticky error.
        state        <= ST_IDLE;
        timer        <= '0;
        o_pl_cfg_crd <= 1'b0;
        o_tx_credits <= '0;
        o_crd_pend   <= '0;
      end else begin
        if (link_up)
          o_tx_credits <= ADP_MAX;
        else if (cons & ~ret & (o_tx_credits != '0))
          o_tx_credits <= o_tx_credits - 1'b1;
        else if (ret & ~cons & (o_tx_credits != ADP_MAX))
          o_tx_credits <= o_tx_credits + 1'b1;

        o_crd_err    <= o_crd_err | (~link_up & (tx_under | tx_over)) | pend_sat;
        o_crd_pend   <= pend_next;
        o_pl_cfg_crd <= issue;

        case (state)
          ST_IDLE: begin
            if (fire) begin
              state <= ST_RETURN;
              timer <= '0;
            end else if (TO_EN & (o_crd_pend != '0) & (o_crd_pend < THR_P)) begin
              timer <= timer + 1'b1;
            end else begin
              timer <= '0;
            end
          end
          ST_RETURN: begin
            // Drain fully, including events that arrive during the burst.
            timer <= '0;
            if (pend_next == '0) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
